// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, state encoding and glyph lookup shared by the seven-segment display
// Contents: GLYPH_0..GLYPH_F, BLANK, DASH, ST_* state constants, state_t enum, glyph()
package seg7_pkg;
   localparam logic [6:0] GLYPH_0 = 7'b0000001;
   localparam logic [6:0] GLYPH_1 = 7'b1001111;
   localparam logic [6:0] GLYPH_2 = 7'b0010010;
   localparam logic [6:0] GLYPH_3 = 7'b0000110;
   localparam logic [6:0] GLYPH_4 = 7'b1001100;
   localparam logic [6:0] GLYPH_5 = 7'b0100100;
   localparam logic [6:0] GLYPH_6 = 7'b0100000;
   localparam logic [6:0] GLYPH_7 = 7'b0001111;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0000100;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b1100000;
   localparam logic [6:0] GLYPH_C = 7'b0110001;
   localparam logic [6:0] GLYPH_D = 7'b1000010;
   localparam logic [6:0] GLYPH_E = 7'b0110000;
   localparam logic [6:0] GLYPH_F = 7'b0111000;
   localparam logic [6:0] BLANK   = 7'b1111111;
   localparam logic [6:0] DASH    = 7'b1111110;
   localparam logic [15:0][6:0] GLYPHS = {GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
                                          GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CONV   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   typedef enum logic [1:0] {IDLE = ST_IDLE, CONV = ST_CONV, COMMIT = ST_COMMIT} state_t;
   function automatic logic [6:0] glyph(input logic [3:0] d);
      return GLYPHS[d];
   endfunction
endpackage

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: sequential double-dabble converter, one input bit per clock
// Ports: clk, reset_n (async, active-low); start loads value and begins WIDTH shift cycles;
//        bcd holds DIGITS packed BCD digits; overflow is set when value >= 10^DIGITS;
//        done is high during the cycle that performs the final shift.
module seg7_bin2bcd #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    value,
   output logic [4*DIGITS-1:0] bcd,
   output logic                overflow,
   output logic                done
);
   localparam int NW = 4*DIGITS;
   localparam int CW = $clog2(WIDTH+1);
   logic [WIDTH-1:0] bin;
   logic [CW-1:0]    cnt;
   logic [NW-1:0]    adj;
   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign adj[4*d +: 4] = (bcd[4*d +: 4] > 4'd4) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
   end
   assign done = cnt == CW'(1);
   // A bit leaving the top digit means the partial value already reached 10^DIGITS;
   // the partial value only grows, so the flag is sticky until the next start.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bin      <= '0;
         bcd      <= '0;
         overflow <= 1'b0;
         cnt      <= '0;
      end else if (start) begin
         bin      <= value;
         bcd      <= '0;
         overflow <= 1'b0;
         cnt      <= CW'(WIDTH);
      end else if (cnt != '0) begin
         bin      <= bin << 1;
         bcd      <= {adj[NW-2:0], bin[WIDTH-1]};
         overflow <= overflow | adj[NW-1];
         cnt      <= cnt - CW'(1);
      end
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: converts a binary value to decimal/hex glyphs and time-multiplexes them onto a 7-segment display
// Ports: clk, reset_n (async, active-low); value/mode captured on load while idle (mode 0 = dec, 1 = hex);
//        busy high during conversion and commit; overflow reflects the last committed value;
//        seg active-low segments (bit6 = a .. bit0 = g); dig_an one-hot-low digit enables, bit0 = LSD.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int WIDTH    = 14,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  value,
   input  logic              load,
   input  logic              mode,
   output logic              busy,
   output logic              overflow,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dig_an
);
   localparam int NW = 4*DIGITS;
   localparam int EW = WIDTH > NW ? WIDTH : NW;
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   state_t                 state;
   logic [WIDTH-1:0]       cap_value;
   logic                   cap_mode;
   logic [EW-1:0]          cap_ext;
   logic [NW-1:0]          nib_q;
   logic [NW-1:0]          bcd;
   logic [NW-1:0]          digits_sel;
   logic                   nov_q;
   logic                   bcd_ovf;
   logic                   bcd_done;
   logic                   ovf_sel;
   logic                   live;
   logic [DIGITS-1:0][6:0] disp_q;
   logic [DIGITS-1:0][6:0] disp_next;
   logic [PW-1:0]          presc;
   logic [IW-1:0]          idx;
   assign busy    = state != IDLE;
   assign cap_ext = EW'(cap_value);
   seg7_bin2bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bin2bcd (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (state == IDLE && load && !mode),
      .value    (value),
      .bcd      (bcd),
      .overflow (bcd_ovf),
      .done     (bcd_done)
   );
   assign digits_sel = cap_mode ? nib_q : bcd;
   assign ovf_sel    = cap_mode ? nov_q : bcd_ovf;
   // A digit above position 0 blanks when it and every digit above it are zero.
   for (genvar d = 0; d < DIGITS; d++) begin : g_disp
      if (d == 0) begin : g_lsd
         assign disp_next[d] = ovf_sel ? DASH : glyph(digits_sel[3:0]);
      end else begin : g_upper
         assign disp_next[d] = ovf_sel ? DASH
                             : (digits_sel[NW-1:4*d] == '0) ? BLANK : glyph(digits_sel[4*d +: 4]);
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state     <= IDLE;
         cap_value <= '0;
         cap_mode  <= 1'b0;
         nib_q     <= '0;
         nov_q     <= 1'b0;
         disp_q    <= {DIGITS{BLANK}};
         overflow  <= 1'b0;
         live      <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (load) begin
                  cap_value <= value;
                  cap_mode  <= mode;
                  state     <= CONV;
               end
            CONV:
               if (cap_mode) begin
                  nib_q <= cap_ext[NW-1:0];
                  nov_q <= |(cap_ext >> NW);
                  state <= COMMIT;
               end else if (bcd_done) begin
                  state <= COMMIT;
               end
            COMMIT: begin
               disp_q   <= disp_next;
               overflow <= ovf_sel;
               live     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   // Digit enables stay dark until something has been committed.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         presc  <= '0;
         idx    <= '0;
         seg    <= BLANK;
         dig_an <= '1;
      end else begin
         presc  <= (presc == PW'(SCAN_DIV-1)) ? '0 : presc + PW'(1);
         idx    <= (presc != PW'(SCAN_DIV-1)) ? idx : (idx == IW'(DIGITS-1)) ? '0 : idx + IW'(1);
         seg    <= disp_q[idx];
         dig_an <= live ? ~(DIGITS'(1) << idx) : '1;
      end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: randomized self-checking bench against an arithmetic display model
module tb_seg7_scan_display;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [13:0] value = '0;
   logic        load = 1'b0;
   logic        mode = 1'b0;
   logic        busy, overflow, busy2, ovf2;
   logic [6:0]  seg, seg2;
   logic [3:0]  dig_an;
   logic [2:0]  dig_an2;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          last_v = 0;
   bit          last_m = 0;
   logic [6:0]  disp_obs [4];
   logic [6:0]  gl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                            7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   seg7_scan_display #(.DIGITS(4), .WIDTH(14), .SCAN_DIV(4)) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .load(load), .mode(mode),
      .busy(busy), .overflow(overflow), .seg(seg), .dig_an(dig_an));

   seg7_scan_display #(.DIGITS(3), .WIDTH(14), .SCAN_DIV(2)) u_small (
      .clk(clk), .reset_n(reset_n), .value(value), .load(load), .mode(mode),
      .busy(busy2), .overflow(ovf2), .seg(seg2), .dig_an(dig_an2));

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_digit(input int v, input bit m, input int i);
      int base, p;
      base = m ? 16 : 10;
      p = base ** i;
      if (v >= base ** 4) return 7'b1111110;
      if (i > 0 && v / p == 0) return 7'b1111111;
      return gl[(v / p) % base];
   endfunction

   task automatic do_load(input int v, input bit m, input int second_at, output int cycles);
      @(negedge clk);
      value = v[13:0];
      mode = m;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         load = (cycles == second_at);
         if (load) begin
            value = 14'd123;
            mode = ~m;
         end
         @(negedge clk);
      end
      load = 1'b0;
      last_v = v;
      last_m = m;
   endtask

   task automatic read_display();
      for (int i = 0; i < 4; i++) disp_obs[i] = 'x;
      repeat (20) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) if (dig_an == ~(4'b0001 << i)) disp_obs[i] = seg;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp += 4;
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL reset seg: got %b want 1111111", seg); end
      if (dig_an !== 4'b1111) begin n_bad++; $display("FAIL reset dig_an: got %b want 1111", dig_an); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      n_cmp += 3;
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL post-reset seg: got %b want 1111111", seg); end
      if (dig_an !== 4'b1111) begin n_bad++; $display("FAIL post-reset dig_an: got %b want 1111", dig_an); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL post-reset busy: got %b want 0", busy); end
   endtask

   task automatic test_dec171();
      int c;
      do_load(171, 0, 0, c);
      read_display();
      n_cmp += 2;
      if (c !== 15) begin n_bad++; $display("FAIL dec171 busy cycles: got %0d want 15", c); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL dec171 overflow: got %b want 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (disp_obs[i] !== exp_digit(171, 0, i)) begin
            n_bad++; $display("FAIL dec171 digit%0d: got %b want %b", i, disp_obs[i], exp_digit(171, 0, i));
         end
      end
   endtask

   task automatic test_hex171();
      int c;
      do_load(171, 1, 0, c);
      read_display();
      n_cmp += 2;
      if (c !== 2) begin n_bad++; $display("FAIL hex171 busy cycles: got %0d want 2", c); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL hex171 overflow: got %b want 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (disp_obs[i] !== exp_digit(171, 1, i)) begin
            n_bad++; $display("FAIL hex171 digit%0d: got %b want %b", i, disp_obs[i], exp_digit(171, 1, i));
         end
      end
   endtask

   task automatic test_overflow();
      int c;
      int vals [2] = '{10000, 9999};
      for (int k = 0; k < 2; k++) begin
         do_load(vals[k], 0, 0, c);
         read_display();
         n_cmp++;
         if (overflow !== (vals[k] >= 10000)) begin
            n_bad++; $display("FAIL ovf%0d overflow: got %b want %b", vals[k], overflow, vals[k] >= 10000);
         end
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (disp_obs[i] !== exp_digit(vals[k], 0, i)) begin
               n_bad++; $display("FAIL ovf%0d digit%0d: got %b want %b", vals[k], i, disp_obs[i], exp_digit(vals[k], 0, i));
            end
         end
      end
   endtask

   task automatic test_scan();
      logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [3:0] prev;
      int old_v, guard;
      bit old_m;
      old_v = last_v;
      old_m = last_m;
      prev = dig_an;
      guard = 0;
      @(negedge clk);
      while (!(dig_an == 4'b1110 && prev == 4'b0111) && guard < 50) begin
         prev = dig_an;
         guard++;
         @(negedge clk);
      end
      n_cmp++;
      if (guard >= 50) begin n_bad++; $display("FAIL scan align: got timeout want slot-0 entry"); end
      for (int j = 0; j < 32; j++) begin
         n_cmp++;
         if (dig_an !== pat[(j / 4) % 4]) begin
            n_bad++; $display("FAIL scan step%0d dig_an: got %b want %b", j, dig_an, pat[(j / 4) % 4]);
         end
         if (j == 8) begin
            n_cmp++;
            if (seg !== exp_digit(old_v, old_m, 2)) begin
               n_bad++; $display("FAIL scan pre-update seg: got %b want %b", seg, exp_digit(old_v, old_m, 2));
            end
         end
         if (j == 9) begin
            n_cmp++;
            if (seg !== exp_digit(12'hABC, 1, 2)) begin
               n_bad++; $display("FAIL scan post-update seg: got %b want %b", seg, exp_digit(12'hABC, 1, 2));
            end
         end
         load = (j == 5);
         if (j == 5) begin
            value = 14'hABC;
            mode = 1'b1;
         end
         @(negedge clk);
      end
      load = 1'b0;
      last_v = 12'hABC;
      last_m = 1;
   endtask

   task automatic test_zero_reload();
      int c;
      do_load(0, 0, 5, c);
      read_display();
      n_cmp += 2;
      if (c !== 15) begin n_bad++; $display("FAIL zero busy cycles: got %0d want 15", c); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL zero overflow: got %b want 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (disp_obs[i] !== exp_digit(0, 0, i)) begin
            n_bad++; $display("FAIL zero digit%0d: got %b want %b", i, disp_obs[i], exp_digit(0, 0, i));
         end
      end
   endtask

   task automatic test_random();
      int c, v;
      bit m;
      for (int k = 0; k < 16; k++) begin
         v = (k % 4 == 0) ? 9990 + $urandom_range(0, 20) : $urandom_range(0, 16383);
         m = 1'($urandom_range(0, 1));
         do_load(v, m, 0, c);
         read_display();
         n_cmp += 2;
         if (c !== (m ? 2 : 15)) begin n_bad++; $display("FAIL rand v=%0d m=%0d busy cycles: got %0d want %0d", v, m, c, m ? 2 : 15); end
         if (overflow !== (!m && v >= 10000)) begin
            n_bad++; $display("FAIL rand v=%0d m=%0d overflow: got %b want %b", v, m, overflow, !m && v >= 10000);
         end
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (disp_obs[i] !== exp_digit(v, m, i)) begin
               n_bad++; $display("FAIL rand v=%0d m=%0d digit%0d: got %b want %b", v, m, i, disp_obs[i], exp_digit(v, m, i));
            end
         end
      end
   endtask

   task automatic test_small_overflow();
      int c;
      int vals [4] = '{4095, 4096, 999, 1000};
      bit mds [4] = '{1, 1, 0, 0};
      bit want;
      for (int k = 0; k < 4; k++) begin
         do_load(vals[k], mds[k], 0, c);
         @(negedge clk);
         want = mds[k] ? vals[k] >= 4096 : vals[k] >= 1000;
         n_cmp += 2;
         if (ovf2 !== want) begin n_bad++; $display("FAIL small v=%0d m=%0d overflow: got %b want %b", vals[k], mds[k], ovf2, want); end
         if (overflow !== 1'b0) begin n_bad++; $display("FAIL main v=%0d m=%0d overflow: got %b want 0", vals[k], mds[k], overflow); end
      end
   endtask

   task automatic test_reset_mid_conv();
      int c;
      @(negedge clk);
      value = 14'd4321;
      mode = 1'b0;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_cmp += 3;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset busy: got %b want 0", busy); end
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL midreset seg: got %b want 1111111", seg); end
      if (dig_an !== 4'b1111) begin n_bad++; $display("FAIL midreset dig_an: got %b want 1111", dig_an); end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp += 3;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL after-abort busy: got %b want 0", busy); end
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL after-abort seg: got %b want 1111111", seg); end
      if (dig_an !== 4'b1111) begin n_bad++; $display("FAIL after-abort dig_an: got %b want 1111", dig_an); end
      do_load(4321, 0, 0, c);
      read_display();
      n_cmp++;
      if (c !== 15) begin n_bad++; $display("FAIL reload busy cycles: got %0d want 15", c); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (disp_obs[i] !== exp_digit(4321, 0, i)) begin
            n_bad++; $display("FAIL reload digit%0d: got %b want %b", i, disp_obs[i], exp_digit(4321, 0, i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_dec171();
      test_hex171();
      test_overflow();
      test_scan();
      test_zero_reload();
      test_random();
      test_small_overflow();
      test_reset_mid_conv();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
